// File: rtl/gpu_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpu_wb_pkg
// Description : Shared types for the register-file writeback arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package gpu_wb_pkg;

    localparam int ADDR_WIDTH = 2;
    localparam int DATA_WIDTH = 8;

    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_LSU = 1'b1
    } wb_src_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/wb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : wb_scoreboard
// Description : Per-register load-pending bits with a sticky double-issue flag.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_scoreboard #(
    parameter int NUM_REGISTERS = 4,
    parameter int ADDR_WIDTH    = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     set_en,
    input  logic [ADDR_WIDTH-1:0]    set_addr,
    input  logic                     clr_en,
    input  logic [ADDR_WIDTH-1:0]    clr_addr,
    output logic [NUM_REGISTERS-1:0] busy_mask,
    output logic                     sb_err
);
    import gpu_wb_pkg::*;

    logic [NUM_REGISTERS-1:0] r_busy;
    logic [NUM_REGISTERS-1:0] w_set;
    logic [NUM_REGISTERS-1:0] w_clr;
    logic                     r_err;
    logic                     w_conflict;

    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (set_en) w_set[set_addr] = 1'b1;
        if (clr_en) w_clr[clr_addr] = 1'b1;
    end

    // A register being retired this cycle may be re-issued without error.
    assign w_conflict = set_en && r_busy[set_addr] && !w_clr[set_addr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy <= '0;
            r_err  <= 1'b0;
        end else begin
            r_busy <= (r_busy & ~w_clr) | w_set;
            if (w_conflict) r_err <= 1'b1;
        end
    end

    assign busy_mask = r_busy;
    assign sb_err    = r_err;

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Round-robin ALU/LSU arbiter for the register-file write port
//               with a registered write strobe. Define GPU_WB_SCOREBOARD_EN
//               to enable load-pending tracking (busy_mask / sb_err).
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int                       DATA_WIDTH    = 8,
    parameter int                       NUM_REGISTERS = 4,
    parameter int                       ADDR_WIDTH    = 2,
    parameter logic [NUM_REGISTERS-1:0] RO_MASK       = '0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [ADDR_WIDTH-1:0]    alu_addr,
    input  logic [DATA_WIDTH-1:0]    alu_data,
    input  logic                     lsu_valid,
    output logic                     lsu_ready,
    input  logic [ADDR_WIDTH-1:0]    lsu_addr,
    input  logic [DATA_WIDTH-1:0]    lsu_data,
    input  logic                     ld_issue,
    input  logic [ADDR_WIDTH-1:0]    ld_issue_dst,
    output logic [NUM_REGISTERS-1:0] busy_mask,
    output logic                     sb_err,
    output logic                     rf_write_en,
    output logic [ADDR_WIDTH-1:0]    rf_write_addr,
    output logic [DATA_WIDTH-1:0]    rf_write_data,
    output logic                     last_grant
);
    import gpu_wb_pkg::*;

    localparam logic [NUM_REGISTERS-1:0] C_RO_MASK = RO_MASK;

    wb_src_e                r_last_grant;
    logic                   r_we;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [DATA_WIDTH-1:0]  r_data;

    logic                   w_alu_grant;
    logic                   w_lsu_grant;
    logic                   w_xfer;
    wb_src_e                w_src;
    logic [ADDR_WIDTH-1:0]  w_addr;
    logic [DATA_WIDTH-1:0]  w_data;

    // Grants double as readies, so they are suppressed while reset is held.
    always_comb begin
        w_alu_grant = 1'b0;
        w_lsu_grant = 1'b0;
        if (reset_n) begin
            if (alu_valid && lsu_valid) begin
                w_alu_grant = (r_last_grant == WB_SRC_LSU);
                w_lsu_grant = (r_last_grant == WB_SRC_ALU);
            end else begin
                w_alu_grant = alu_valid;
                w_lsu_grant = lsu_valid;
            end
        end
    end

    assign alu_ready = w_alu_grant;
    assign lsu_ready = w_lsu_grant;
    assign w_xfer    = w_alu_grant | w_lsu_grant;
    assign w_src     = w_lsu_grant ? WB_SRC_LSU : WB_SRC_ALU;
    assign w_addr    = w_lsu_grant ? lsu_addr : alu_addr;
    assign w_data    = w_lsu_grant ? lsu_data : alu_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_last_grant <= WB_SRC_LSU;
        end else if (w_xfer) begin
            // Read-only targets still complete the handshake; only the strobe is dropped.
            r_we         <= !C_RO_MASK[w_addr];
            r_addr       <= w_addr;
            r_data       <= w_data;
            r_last_grant <= w_src;
        end else begin
            r_we         <= 1'b0;
        end
    end

    assign rf_write_en   = r_we;
    assign rf_write_addr = r_addr;
    assign rf_write_data = r_data;
    assign last_grant    = r_last_grant;

`ifdef GPU_WB_SCOREBOARD_EN
    wb_scoreboard #(
        .NUM_REGISTERS (NUM_REGISTERS),
        .ADDR_WIDTH    (ADDR_WIDTH)
    ) u_scoreboard (
        .clk       (clk),
        .reset_n   (reset_n),
        .set_en    (ld_issue),
        .set_addr  (ld_issue_dst),
        .clr_en    (w_lsu_grant),
        .clr_addr  (lsu_addr),
        .busy_mask (busy_mask),
        .sb_err    (sb_err)
    );
`else
    logic w_unused_ld;
    assign w_unused_ld = ^{ld_issue, ld_issue_dst};
    assign busy_mask   = '0;
    assign sb_err      = 1'b0;
`endif

endmodule
`default_nettype wire
